// File: rtl/div_cfg_pkg.sv
// Shared definitions for the divider reconfiguration controller: FSM
// encoding, the legal UART prescale table with decoded RX ratios, and the
// divider ratios that apply coming out of reset.
package div_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOAD   = 2'd2,
        ST_ENABLE = 2'd3
    } cfg_state_e;

    // Legal prescale values and their RX divide ratios, index-aligned.
    localparam int NUM_PRESCALE = 3;
    localparam logic [NUM_PRESCALE-1:0][5:0] PRESCALE_VAL   = {6'd32, 6'd16, 6'd8};
    localparam logic [NUM_PRESCALE-1:0][7:0] PRESCALE_RATIO = {8'd1,  8'd2,  8'd4};

    // Divider ratios after reset.
    localparam logic [7:0] RX_RST_DEFAULT = 8'd1;
    localparam logic [7:0] TX_RST_DEFAULT = 8'd32;

    // Settle counter width; SETTLE_CYC tops out at 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/prescale_decode.sv
// Combinational prescale-to-RX-ratio decode plus request legality check.
// An unknown prescale decodes to ratio 0 and is flagged illegal, as is a
// zero TX divide ratio.
module prescale_decode
    import div_cfg_pkg::*;
(
    input  logic [5:0] prescale,
    input  logic [7:0] tx_div,
    output logic [7:0] rx_ratio,
    output logic       legal
);

    logic [NUM_PRESCALE-1:0]       hit;
    logic [NUM_PRESCALE-1:0][7:0]  masked_ratio;

    // One comparator per table entry; each contributes its ratio on a hit.
    generate
        for (genvar gi = 0; gi < NUM_PRESCALE; gi++) begin : g_entry
            assign hit[gi]          = (prescale == PRESCALE_VAL[gi]);
            assign masked_ratio[gi] = hit[gi] ? PRESCALE_RATIO[gi] : 8'd0;
        end
    endgenerate

    // Entries are mutually exclusive, so OR-merging the masked ratios is safe.
    always_comb begin
        rx_ratio = 8'd0;
        for (int i = 0; i < NUM_PRESCALE; i++) begin
            rx_ratio = rx_ratio | masked_ratio[i];
        end
    end

    assign legal = (|hit) && (tx_div != 8'd0);

endmodule

// File: rtl/div_cfg_ctrl.sv
// Divider reconfiguration controller. A legal, changed request disables
// both clock dividers, waits SETTLE_CYC cycles, loads the new ratios while
// the dividers are off, then re-enables them. Requests arriving while a
// sequence runs collapse into one pending request serviced on return to
// IDLE. Immediate outcomes (illegal, or no change) are reported one cycle
// after the accepting edge.
module div_cfg_ctrl
    import div_cfg_pkg::*;
#(
    parameter int unsigned SETTLE_CYC   = 4,
    parameter logic [7:0]  RX_RST_RATIO = RX_RST_DEFAULT,
    parameter logic [7:0]  TX_RST_RATIO = TX_RST_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] cfg_prescale,
    input  logic [7:0] cfg_tx_div,
    input  logic       cfg_req,
    output logic [7:0] o_rx_div_ratio,
    output logic [7:0] o_tx_div_ratio,
    output logic       o_div_en,
    output logic       o_cfg_busy,
    output logic       o_cfg_done,
    output logic       o_cfg_err
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    cfg_state_e       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             pend_reg, pend_next;
    logic [7:0]       rx_shadow_reg, rx_shadow_next;
    logic [7:0]       tx_shadow_reg, tx_shadow_next;
    logic [7:0]       rx_ratio_reg, rx_ratio_next;
    logic [7:0]       tx_ratio_reg, tx_ratio_next;
    logic             div_en_reg, div_en_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;
    logic             done_dly_reg, done_dly_next;
    logic             err_dly_reg, err_dly_next;

    logic [7:0]       dec_rx;
    logic             dec_legal;
    logic             take_req;

    prescale_decode u_decode (
        .prescale (cfg_prescale),
        .tx_div   (cfg_tx_div),
        .rx_ratio (dec_rx),
        .legal    (dec_legal)
    );

    // A request is taken in IDLE, either fresh or left pending by a sequence.
    assign take_req = (state_reg == ST_IDLE) && (cfg_req || pend_reg);

    // State register; reset restores the post-reset ratios and drops any
    // sequence or pending request in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            pend_reg      <= 1'b0;
            rx_shadow_reg <= RX_RST_RATIO;
            tx_shadow_reg <= TX_RST_RATIO;
            rx_ratio_reg  <= RX_RST_RATIO;
            tx_ratio_reg  <= TX_RST_RATIO;
            div_en_reg    <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            done_dly_reg  <= 1'b0;
            err_dly_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            pend_reg      <= pend_next;
            rx_shadow_reg <= rx_shadow_next;
            tx_shadow_reg <= tx_shadow_next;
            rx_ratio_reg  <= rx_ratio_next;
            tx_ratio_reg  <= tx_ratio_next;
            div_en_reg    <= div_en_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            done_dly_reg  <= done_dly_next;
            err_dly_reg   <= err_dly_next;
        end
    end

    // Next-state and output logic for the reconfiguration sequence.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        pend_next      = pend_reg;
        rx_shadow_next = rx_shadow_reg;
        tx_shadow_next = tx_shadow_reg;
        rx_ratio_next  = rx_ratio_reg;
        tx_ratio_next  = tx_ratio_reg;
        div_en_next    = div_en_reg;
        busy_next      = busy_reg;
        // Immediate outcomes surface one cycle after they were decided.
        done_next      = done_dly_reg;
        err_next       = err_dly_reg;
        done_dly_next  = 1'b0;
        err_dly_next   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (take_req) begin
                    pend_next = 1'b0;
                    if (!dec_legal) begin
                        err_dly_next = 1'b1;
                    end else if ((dec_rx == rx_ratio_reg) && (cfg_tx_div == tx_ratio_reg)) begin
                        done_dly_next = 1'b1;
                    end else begin
                        rx_shadow_next = dec_rx;
                        tx_shadow_next = cfg_tx_div;
                        div_en_next    = 1'b0;
                        busy_next      = 1'b1;
                        cnt_next       = '0;
                        state_next     = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (cfg_req) pend_next = 1'b1;
                if (cnt_reg == SETTLE_LAST) begin
                    state_next = ST_LOAD;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_LOAD: begin
                if (cfg_req) pend_next = 1'b1;
                rx_ratio_next = rx_shadow_reg;
                tx_ratio_next = tx_shadow_reg;
                state_next    = ST_ENABLE;
            end
            ST_ENABLE: begin
                if (cfg_req) pend_next = 1'b1;
                div_en_next = 1'b1;
                done_next   = 1'b1;
                busy_next   = 1'b0;
                state_next  = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign o_rx_div_ratio = rx_ratio_reg;
    assign o_tx_div_ratio = tx_ratio_reg;
    assign o_div_en       = div_en_reg;
    assign o_cfg_busy     = busy_reg;
    assign o_cfg_done     = done_reg;
    assign o_cfg_err      = err_reg;

endmodule

// File: doc/div_cfg_ctrl.md
DIV_CFG_CTRL -- requirements
Module: div_cfg_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 4: cycles the dividers stay disabled before new ratios load; legal range 1..15.
REQ-002 Parameter RX_RST_RATIO, default 8'd1: RX divide ratio after reset.
REQ-003 Parameter TX_RST_RATIO, default 8'd32: TX divide ratio after reset.
REQ-004 CLK  in  1  single system clock; all state changes on its rising edge.
REQ-005 RST  in  1  asynchronous, active-high reset.
REQ-006 cfg_prescale  in  6  UART prescale from the register file; legal values are 8, 16 and 32.
REQ-007 cfg_tx_div  in  8  requested TX divide ratio from the register file; 0 is illegal.
REQ-008 cfg_req  in  1  single-cycle pulse requesting that the cfg_* inputs be applied.
REQ-009 o_rx_div_ratio  out  8  registered RX divider ratio.
REQ-010 o_tx_div_ratio  out  8  registered TX divider ratio.
REQ-011 o_div_en  out  1  enable for both clock dividers.
REQ-012 o_cfg_busy  out  1  high while a reconfiguration sequence runs.
REQ-013 o_cfg_done  out  1  one-cycle pulse when a request completes.
REQ-014 o_cfg_err  out  1  one-cycle pulse when a request is rejected.

Function
REQ-015 Prescale decode: 8->4, 16->2, 32->1; any other value makes the request illegal.
REQ-016 A request is illegal if the prescale is illegal or cfg_tx_div==0.
REQ-017 Validation uses the cfg_* values sampled on the edge that accepts the request (edge E0).
REQ-018 Illegal request: o_cfg_err pulses at E0+1; ratios, o_div_en and state are unchanged; no done pulse.
REQ-019 Legal request whose decoded ratios equal the current outputs: o_cfg_done pulses at E0+1; o_div_en stays high; no sequence runs.
REQ-020 FSM states: IDLE, SETTLE, LOAD, ENABLE.
REQ-021 IDLE->SETTLE on a legal, changed request; at E0: shadow ratios captured, o_div_en<=0, o_cfg_busy<=1, settle counter<=0.
REQ-022 SETTLE: counter increments each cycle; the FSM enters LOAD when the counter reaches SETTLE_CYC-1 (exit at E0+SETTLE_CYC).
REQ-023 LOAD, one cycle: ratio outputs take the shadow values at E0+SETTLE_CYC+1; the FSM enters ENABLE.
REQ-024 ENABLE, one cycle: at E0+SETTLE_CYC+2, o_div_en<=1, o_cfg_done pulses, o_cfg_busy<=0, FSM returns to IDLE.
REQ-025 Ratio outputs SHALL never change while o_div_en is high, and never in the same cycle o_div_en changes.
REQ-026 cfg_req while busy sets a pending flag; multiple such requests collapse into one.
REQ-027 A pending request is accepted on the first IDLE cycle, sampling cfg_* at that edge; the pending flag then clears.
REQ-028 cfg_req coinciding with the ENABLE cycle is treated as pending, not dropped.
REQ-029 o_cfg_done and o_cfg_err are mutually exclusive in any cycle.

Reset
REQ-030 RST high immediately (asynchronously) forces: FSM=IDLE, o_rx_div_ratio=RX_RST_RATIO, o_tx_div_ratio=TX_RST_RATIO, o_div_en=1, o_cfg_busy=0, o_cfg_done=0, o_cfg_err=0, pending=0, counter=0.
REQ-031 Reset asserted mid-sequence discards the sequence and the pending request; the reset ratios apply.
REQ-032 The first request is accepted on the first clock edge after RST deasserts.

Structure
REQ-033 Shared package div_cfg_pkg SHALL hold: the FSM state encoding, the legal prescale constants (8, 16, 32) with their decoded ratios, and the reset ratio defaults.
REQ-034 Prescale decode and legality checking SHALL live in a combinational sub-module, prescale_decode, instantiated once.
REQ-035 All outputs SHALL be registered; no output is driven combinationally from an input.

Verification
REQ-036 Reset, then idle 10 cycles -> rx=1, tx=32, en=1, busy=0, no pulses.
REQ-037 prescale=8, tx_div=16, req at E0, SETTLE_CYC=4 -> en low E0..E6; rx=4 and tx=16 at E5; en=1 and done pulse at E6.
REQ-038 prescale=12 req, then tx_div=0 req -> err pulse each time at E0+1; ratios unchanged; en stays 1.
REQ-039 Request with the current config (prescale=32, tx_div=32) -> done at E0+1; en never drops.
REQ-040 Three requests during SETTLE, the last with prescale=16 -> exactly one follow-up sequence, final rx=2, two done pulses total.
REQ-041 RST asserted during LOAD -> outputs back to 1/32, en=1 asynchronously; no done pulse follows.
